// File: rtl/ixc_skid_34_pkg.sv
// ixc_skid_pkg: shared state encoding and default sizes for the ixc_skid_34 skid buffer.
// State encodings double as the occupancy count.
package ixc_skid_pkg;
    localparam int IXC_SKID_WIDTH = 34;
    localparam int IXC_SKID_CNT_W = 16;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;
endpackage

// File: rtl/ixc_skid_34_if.sv
// ixc_skid_34_if: valid/ready handshake bundle for ixc_skid_34.
// IXC_SKID_PARITY_EN adds in_par and par_err to the bundle.
interface ixc_skid_34_if
    import ixc_skid_pkg::*;
#(
    parameter int WIDTH = IXC_SKID_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef IXC_SKID_PARITY_EN
    logic             in_par;
    logic             par_err;
    modport master (output in_valid, in_data, in_par, out_ready,
                    input in_ready, out_valid, out_data, par_err);
    modport slave  (input in_valid, in_data, in_par, out_ready,
                    output in_ready, out_valid, out_data, par_err);
`else
    modport master (output in_valid, in_data, out_ready,
                    input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/ixc_skid_34_sat_cnt.sv
// ixc_sat_cnt: saturating up-counter with synchronous clear, used for the stall counter.
module ixc_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/ixc_skid_34.sv
// ixc_skid_34: registered two-entry valid/ready skid buffer with a saturating stall counter.
// IXC_SKID_PARITY_EN stores even parity with each word and flags a sticky par_err on bad output.
module ixc_skid_34
    import ixc_skid_pkg::*;
#(
    parameter int WIDTH = IXC_SKID_WIDTH,
    parameter int CNT_W = IXC_SKID_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    ixc_skid_34_if.slave     bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);
`ifdef IXC_SKID_PARITY_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    skid_state_t state_q;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_word;
    logic          out_valid_q;
    logic          in_ready_q;
    logic          in_fire;
    logic          out_fire;

`ifdef IXC_SKID_PARITY_EN
    assign in_word = {bus.in_par, bus.in_data};
`else
    assign in_word = bus.in_data;
`endif
    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // flush wins over any handshake; data registers keep their contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_q     <= ONE;
                    main_q      <= in_word;
                    out_valid_q <= 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) main_q <= in_word;
                    else if (in_fire) begin
                        state_q    <= FULL;
                        skid_q     <= in_word;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: if (out_fire) begin
                    state_q    <= ONE;
                    main_q     <= skid_q;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef IXC_SKID_PARITY_EN
    logic par_err_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                   par_err_q <= 1'b0;
        else if (flush)               par_err_q <= 1'b0;
        else if (out_fire && ^main_q) par_err_q <= 1'b1;
    assign bus.par_err = par_err_q;
`endif

    assign bus.out_data  = main_q[WIDTH-1:0];
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign occupancy     = state_q;

    ixc_sat_cnt #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q & ~bus.out_ready),
        .clr   (flush),
        .cnt   (stall_cnt)
    );
endmodule

// File: tb/tb_ixc_skid_34.sv
// tb_ixc_skid_34: directed vector bench for ixc_skid_34, with a 4-bit stall counter copy for saturation.
module tb_ixc_skid_34;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  occ;
    logic [1:0]  occ4;
    logic [15:0] st;
    logic [3:0]  st4;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ixc_skid_34_if ifm ();
    ixc_skid_34_if if4 ();
    assign if4.in_valid  = ifm.in_valid;
    assign if4.in_data   = ifm.in_data;
    assign if4.out_ready = ifm.out_ready;
`ifdef IXC_SKID_PARITY_EN
    logic par_flip = 1'b0;
    assign ifm.in_par = (^ifm.in_data) ^ par_flip;
    assign if4.in_par = ifm.in_par;
`endif

    ixc_skid_34 dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifm.slave), .occupancy(occ), .stall_cnt(st));
    ixc_skid_34 #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if4.slave), .occupancy(occ4), .stall_cnt(st4));

    typedef struct {
        logic        iv;
        logic [33:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic        ir;
        logic [33:0] od;
        logic [1:0]  occ;
        logic [15:0] st;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{1'b1, 34'h2_DEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, 34'h2_DEAD_BEEF, 2'd1, 16'd0};
        v[1]  = '{1'b0, 34'h0,           1'b1, 1'b0, 1'b0, 1'b1, 34'h2_DEAD_BEEF, 2'd0, 16'd0};
        v[2]  = '{1'b1, 34'h1,           1'b0, 1'b0, 1'b1, 1'b1, 34'h1,           2'd1, 16'd0};
        v[3]  = '{1'b1, 34'h2,           1'b0, 1'b0, 1'b1, 1'b0, 34'h1,           2'd2, 16'd1};
        v[4]  = '{1'b1, 34'h3,           1'b0, 1'b0, 1'b1, 1'b0, 34'h1,           2'd2, 16'd2};
        v[5]  = '{1'b1, 34'h3,           1'b1, 1'b0, 1'b1, 1'b1, 34'h2,           2'd1, 16'd2};
        v[6]  = '{1'b1, 34'h3,           1'b1, 1'b0, 1'b1, 1'b1, 34'h3,           2'd1, 16'd2};
        v[7]  = '{1'b0, 34'h0,           1'b1, 1'b0, 1'b0, 1'b1, 34'h3,           2'd0, 16'd2};
        v[8]  = '{1'b1, 34'h10,          1'b0, 1'b0, 1'b1, 1'b1, 34'h10,          2'd1, 16'd2};
        v[9]  = '{1'b1, 34'h11,          1'b0, 1'b0, 1'b1, 1'b0, 34'h10,          2'd2, 16'd3};
        v[10] = '{1'b1, 34'h12,          1'b1, 1'b1, 1'b0, 1'b1, 34'h10,          2'd0, 16'd0};
        v[11] = '{1'b0, 34'h0,           1'b1, 1'b0, 1'b0, 1'b1, 34'h10,          2'd0, 16'd0};
        v[12] = '{1'b1, 34'h3_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 34'h3_FFFF_FFFF, 2'd1, 16'd0};
        v[13] = '{1'b0, 34'h0,           1'b1, 1'b0, 1'b0, 1'b1, 34'h3_FFFF_FFFF, 2'd0, 16'd0};

        ifm.in_valid  = 1'b1;
        ifm.in_data   = 34'h2_DEAD_BEEF;
        ifm.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 64'(ifm.out_valid), 64'd0);
        chk("rst_in_ready",  64'(ifm.in_ready),  64'd1);
        chk("rst_occ",       64'(occ),           64'd0);
        chk("rst_stall",     64'(st),            64'd0);
        chk("rst_out_data",  64'(ifm.out_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            ifm.in_valid  = v[i].iv;
            ifm.in_data   = v[i].d;
            ifm.out_ready = v[i].ordy;
            flush         = v[i].fl;
            step();
            chk($sformatf("v%0d_out_valid", i), 64'(ifm.out_valid), 64'(v[i].ov));
            chk($sformatf("v%0d_in_ready", i),  64'(ifm.in_ready),  64'(v[i].ir));
            chk($sformatf("v%0d_out_data", i),  64'(ifm.out_data),  64'(v[i].od));
            chk($sformatf("v%0d_occ", i),       64'(occ),           64'(v[i].occ));
            chk($sformatf("v%0d_stall", i),     64'(st),            64'(v[i].st));
        end
        flush = 1'b0;

        ifm.in_valid  = 1'b1;
        ifm.in_data   = 34'h55;
        ifm.out_ready = 1'b0;
        step();
        ifm.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("sat_stall16_%0d", k), 64'(st),  64'(k));
            chk($sformatf("sat_stall4_%0d", k),  64'(st4), 64'(k > 15 ? 15 : k));
            chk($sformatf("sat_hold_%0d", k),    64'(ifm.out_data), 64'h55);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_flush_stall16", 64'(st),            64'd0);
        chk("sat_flush_stall4",  64'(st4),           64'd0);
        chk("sat_flush_valid",   64'(ifm.out_valid), 64'd0);
        chk("sat_flush_occ",     64'(occ),           64'd0);

        ifm.out_ready = 1'b1;
        ifm.in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ifm.in_data = 34'(i);
            step();
            chk($sformatf("stream_%0d", i),
                {ifm.out_valid, ifm.in_ready, occ, 26'd0, ifm.out_data},
                {1'b1, 1'b1, 2'd1, 26'd0, 34'(i)});
        end
        ifm.in_valid = 1'b0;
        step();
        chk("stream_drain_occ", 64'(occ), 64'd0);
        chk("stream_stall",     64'(st),  64'd0);

`ifdef IXC_SKID_PARITY_EN
        ifm.in_valid = 1'b1;
        par_flip     = 1'b1;
        ifm.in_data  = 34'h7;
        step();
        chk("par_before_fire", 64'(ifm.par_err), 64'd0);
        par_flip    = 1'b0;
        ifm.in_data = 34'h8;
        step();
        chk("par_set", 64'(ifm.par_err), 64'd1);
        ifm.in_data = 34'h9;
        step();
        ifm.in_valid = 1'b0;
        step();
        chk("par_sticky", 64'(ifm.par_err), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("par_flush", 64'(ifm.par_err), 64'd0);
`endif

        ifm.in_valid  = 1'b1;
        ifm.in_data   = 34'h1_2345_6789;
        ifm.out_ready = 1'b0;
        step();
        chk("mid_loaded", 64'(occ), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(ifm.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(ifm.in_ready),  64'd1);
        chk("mid_rst_occ",   64'(occ),           64'd0);
        chk("mid_rst_data",  64'(ifm.out_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifm.in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
